// File: rtl/rvc_asap_5pl_vga_pkg.sv
// Shared framebuffer geometry and fill-engine state encoding
// for the 640x480 1bpp VGA memory.
package rvc_asap_5pl_vga_pkg;

  localparam int VGA_WORDS_PER_LINE = 80;
  localparam int VGA_LINES          = 480;
  localparam int VGA_LINES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/rvc_asap_5pl_vga_fb_addr.sv
// (line, byte-column) -> framebuffer word index and byte lane enable.
// Four display lines share one word, one byte lane each.
module rvc_asap_5pl_vga_fb_addr
  import rvc_asap_5pl_vga_pkg::*;
(
  input  logic [8:0]  i_line,
  input  logic [6:0]  i_col,
  output logic [13:0] o_word,
  output logic [3:0]  o_byteena
);

  logic [13:0] w_row;
  logic [13:0] w_col;

  assign w_row = {7'd0, i_line[8:2]};
  assign w_col = {7'd0, i_col};

  // 14 bits hold the largest word index (9599)
  assign o_word    = w_row * 14'(VGA_WORDS_PER_LINE) + w_col;
  assign o_byteena = 4'b0001 << i_line[1:0];

endmodule

// File: rtl/rvc_asap_5pl_vga_fill_eng.sv
// Rectangle-fill engine sharing the VGA memory port with the core.
// Core requests always win; the engine stalls with counters held.
module rvc_asap_5pl_vga_fill_eng
  import rvc_asap_5pl_vga_pkg::*;
#(
  parameter logic [31:0] VGA_BASE = 32'h0000_0000,
  parameter int          MAX_COL  = 79,
  parameter int          MAX_LINE = 479
) (
  input  logic        CLK_50,
  input  logic        Reset,
  input  logic [31:0] core_data,
  input  logic [31:0] core_address,
  input  logic [3:0]  core_byteena,
  input  logic        core_wren,
  input  logic        core_rden,
  output logic [31:0] core_q,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_col0,
  input  logic [6:0]  cmd_col1,
  input  logic [8:0]  cmd_line0,
  input  logic [8:0]  cmd_line1,
  input  logic [7:0]  cmd_pattern,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] vga_data,
  output logic [31:0] vga_address,
  output logic [3:0]  vga_byteena,
  output logic        vga_wren,
  output logic        vga_rden,
  input  logic [31:0] vga_q
);

  localparam logic [6:0] LP_MAX_COL  = 7'(MAX_COL);
  localparam logic [8:0] LP_MAX_LINE = 9'(MAX_LINE);

  fill_state_e r_state;
  fill_state_e w_next;

  logic [6:0] r_col0;
  logic [6:0] r_col1;
  logic [8:0] r_line1;
  logic [7:0] r_pat;
  logic [6:0] r_cur_col;
  logic [8:0] r_cur_line;
  logic       r_err;

  logic        w_core_req;
  logic        w_accept;
  logic        w_illegal;
  logic        w_eng_wr;
  logic        w_last_col;
  logic        w_last_line;
  logic [13:0] w_word;
  logic [3:0]  w_be;

  assign w_core_req  = core_wren | core_rden;
  assign w_accept    = (r_state == IDLE) & cmd_valid;
  assign w_illegal   = (cmd_col0 > cmd_col1)
                     | (cmd_line0 > cmd_line1)
                     | (cmd_col1 > LP_MAX_COL)
                     | (cmd_line1 > LP_MAX_LINE);
  assign w_eng_wr    = (r_state == FILL) & ~w_core_req;
  assign w_last_col  = (r_cur_col == r_col1);
  assign w_last_line = (r_cur_line == r_line1);

  assign core_q = vga_q;

  rvc_asap_5pl_vga_fb_addr u_fb_addr (
    .i_line    (r_cur_line),
    .i_col     (r_cur_col),
    .o_word    (w_word),
    .o_byteena (w_be)
  );

  always_ff @(posedge CLK_50 or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = w_illegal ? DONE : FILL;
      FILL: if (w_eng_wr & w_last_col & w_last_line) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != IDLE);
    cmd_ready   = (r_state == IDLE);
    done        = (r_state == DONE);
    err         = (r_state == DONE) & r_err;
    vga_data    = core_data;
    vga_address = core_address;
    vga_byteena = core_byteena;
    vga_wren    = core_wren;
    vga_rden    = core_rden;
    if (w_eng_wr) begin
      vga_data    = {4{r_pat}};
      vga_address = VGA_BASE + {16'd0, w_word, 2'b00};
      vga_byteena = w_be;
      vga_wren    = 1'b1;
      vga_rden    = 1'b0;
    end
  end

  always_ff @(posedge CLK_50 or posedge Reset) begin
    if (Reset) begin
      r_col0     <= '0;
      r_col1     <= '0;
      r_line1    <= '0;
      r_pat      <= '0;
      r_cur_col  <= '0;
      r_cur_line <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_col0     <= cmd_col0;
      r_col1     <= cmd_col1;
      r_line1    <= cmd_line1;
      r_pat      <= cmd_pattern;
      r_cur_col  <= cmd_col0;
      r_cur_line <= cmd_line0;
      r_err      <= w_illegal;
    end else if (w_eng_wr) begin
      // column runs inner, line outer
      if (w_last_col) begin
        r_cur_col  <= r_col0;
        r_cur_line <= r_cur_line + 9'd1;
      end else begin
        r_cur_col  <= r_cur_col + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_rvc_asap_5pl_vga_fill_eng.sv
// Directed bench for the VGA rectangle-fill engine.
module tb_rvc_asap_5pl_vga_fill_eng;

  logic        CLK_50 = 1'b0;
  logic        Reset;
  logic [31:0] core_data;
  logic [31:0] core_address;
  logic [3:0]  core_byteena;
  logic        core_wren;
  logic        core_rden;
  logic [31:0] core_q;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_col0;
  logic [6:0]  cmd_col1;
  logic [8:0]  cmd_line0;
  logic [8:0]  cmd_line1;
  logic [7:0]  cmd_pattern;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] vga_data;
  logic [31:0] vga_address;
  logic [3:0]  vga_byteena;
  logic        vga_wren;
  logic        vga_rden;
  logic [31:0] vga_q;

  int checks = 0;
  int errors = 0;

  always #10 CLK_50 = ~CLK_50;

  rvc_asap_5pl_vga_fill_eng dut (
    .CLK_50       (CLK_50),
    .Reset        (Reset),
    .core_data    (core_data),
    .core_address (core_address),
    .core_byteena (core_byteena),
    .core_wren    (core_wren),
    .core_rden    (core_rden),
    .core_q       (core_q),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_col0     (cmd_col0),
    .cmd_col1     (cmd_col1),
    .cmd_line0    (cmd_line0),
    .cmd_line1    (cmd_line1),
    .cmd_pattern  (cmd_pattern),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .vga_data     (vga_data),
    .vga_address  (vga_address),
    .vga_byteena  (vga_byteena),
    .vga_wren     (vga_wren),
    .vga_rden     (vga_rden),
    .vga_q        (vga_q)
  );

  // Presents a command for one accept edge; returns #1 into cycle 1.
  task automatic send_cmd(input logic [6:0] c0, input logic [6:0] c1,
                          input logic [8:0] l0, input logic [8:0] l1,
                          input logic [7:0] pat);
    @(negedge CLK_50);
    cmd_col0 = c0; cmd_col1 = c1;
    cmd_line0 = l0; cmd_line1 = l1;
    cmd_pattern = pat; cmd_valid = 1'b1;
    @(negedge CLK_50);
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    core_data = 32'hCAFE_0001; core_address = 32'h0000_0404;
    core_byteena = 4'b1010; core_wren = 1'b1; core_rden = 1'b0;
    vga_q = 32'h1234_5678;
    cmd_valid = 1'b0; cmd_col0 = '0; cmd_col1 = '0;
    cmd_line0 = '0; cmd_line1 = '0; cmd_pattern = '0;
    repeat (2) @(negedge CLK_50);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b err=%b rdy=%b want 0 0 0 1",
               busy, done, err, cmd_ready);
    end
    checks++;
    if (vga_address !== 32'h0000_0404 || vga_data !== 32'hCAFE_0001 ||
        vga_byteena !== 4'b1010 || vga_wren !== 1'b1 || vga_rden !== 1'b0) begin
      errors++;
      $display("FAIL reset_passthru: a=%h d=%h be=%b w=%b r=%b want 404 cafe0001 1010 1 0",
               vga_address, vga_data, vga_byteena, vga_wren, vga_rden);
    end
    checks++;
    if (core_q !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reset_core_q: got %h want 12345678", core_q);
    end
    @(negedge CLK_50);
    Reset = 1'b0;
    core_wren = 1'b0; core_byteena = 4'b0000;
    core_rden = 1'b1; core_address = 32'h0000_0800;
    #1;
    checks++;
    if (vga_rden !== 1'b1 || vga_wren !== 1'b0 || vga_address !== 32'h0000_0800) begin
      errors++;
      $display("FAIL idle_read_passthru: r=%b w=%b a=%h want 1 0 800",
               vga_rden, vga_wren, vga_address);
    end
    core_rden = 1'b0;
  endtask

  task automatic test_single;
    send_cmd(7'd5, 7'd5, 9'd6, 9'd6, 8'hA5);
    checks++;
    if (vga_wren !== 1'b1 || vga_address !== 32'h154 || vga_byteena !== 4'b0100 ||
        vga_data !== 32'hA5A5_A5A5 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_write: w=%b a=%h be=%b d=%h busy=%b rdy=%b want 1 154 0100 a5a5a5a5 1 0",
               vga_wren, vga_address, vga_byteena, vga_data, busy, cmd_ready);
    end
    @(negedge CLK_50); #1;
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || vga_wren !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b err=%b w=%b want 1 0 0", done, err, vga_wren);
    end
    @(negedge CLK_50); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: done=%b busy=%b rdy=%b want 0 0 1", done, busy, cmd_ready);
    end
  endtask

  // Full 80x4 fill; optional core store burst of stall_len cycles from stall_at.
  task automatic test_fill(input int stall_at, input int stall_len);
    int writes = 0;
    int cyc = 1;
    int ecol = 0;
    int eline = 0;
    logic stall;
    logic [31:0] eaddr;
    send_cmd(7'd0, 7'd79, 9'd0, 9'd3, 8'hFF);
    while (writes < 320 && cyc < 400) begin
      stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      core_wren = stall;
      core_byteena = stall ? 4'hF : 4'h0;
      core_address = 32'h0000_2000 + 32'(cyc);
      core_data = 32'hDEAD_0000 + 32'(cyc);
      #1;
      checks++;
      if (stall) begin
        if (vga_wren !== 1'b1 || vga_address !== 32'h0000_2000 + 32'(cyc) ||
            vga_data !== 32'hDEAD_0000 + 32'(cyc) || vga_byteena !== 4'hF) begin
          errors++;
          $display("FAIL core_priority cyc%0d: a=%h d=%h be=%b", cyc,
                   vga_address, vga_data, vga_byteena);
        end
      end else begin
        eaddr = 32'((((eline >> 2) * 80) + ecol) * 4);
        if (vga_wren !== 1'b1 || vga_rden !== 1'b0 || vga_address !== eaddr ||
            vga_byteena !== (4'b0001 << eline[1:0]) || vga_data !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL fill_write cyc%0d: w=%b a=%h be=%b d=%h want a=%h line=%0d",
                   cyc, vga_wren, vga_address, vga_byteena, vga_data, eaddr, eline);
        end
        writes++;
        if (ecol == 79) begin ecol = 0; eline++; end
        else ecol++;
      end
      @(negedge CLK_50);
      cyc++;
    end
    core_wren = 1'b0; core_byteena = 4'h0;
    #1;
    checks++;
    if (cyc !== 321 + stall_len || done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL fill_done: cyc=%0d done=%b err=%b want cyc=%0d 1 0",
               cyc, done, err, 321 + stall_len);
    end
    @(negedge CLK_50); #1;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL fill_idle: busy=%b rdy=%b done=%b want 0 1 0", busy, cmd_ready, done);
    end
  endtask

  task automatic test_illegal;
    logic [6:0] c0 [3] = '{7'd10, 7'd0, 7'd0};
    logic [6:0] c1 [3] = '{7'd9,  7'd80, 7'd3};
    logic [8:0] l1 [3] = '{9'd0,  9'd0, 9'd480};
    for (int i = 0; i < 3; i++) begin
      send_cmd(c0[i], c1[i], 9'd0, l1[i], 8'h3C);
      checks++;
      if (done !== 1'b1 || err !== 1'b1 || vga_wren !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL illegal_%0d: done=%b err=%b w=%b rdy=%b want 1 1 0 0",
                 i, done, err, vga_wren, cmd_ready);
      end
      @(negedge CLK_50); #1;
      checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || vga_wren !== 1'b0) begin
        errors++;
        $display("FAIL illegal_ready_%0d: rdy=%b done=%b err=%b w=%b want 1 0 0 0",
                 i, cmd_ready, done, err, vga_wren);
      end
    end
  endtask

  task automatic test_boundary;
    logic [31:0] ea [4] = '{32'h0, 32'h0, 32'h140, 32'h140};
    logic [3:0]  eb [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    send_cmd(7'd79, 7'd79, 9'd479, 9'd479, 8'h81);
    checks++;
    if (vga_wren !== 1'b1 || vga_address !== 32'h95FC || vga_byteena !== 4'b1000 ||
        vga_data !== 32'h8181_8181) begin
      errors++;
      $display("FAIL corner_write: w=%b a=%h be=%b d=%h want 1 95fc 1000 81818181",
               vga_wren, vga_address, vga_byteena, vga_data);
    end
    @(negedge CLK_50); #1;
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL corner_done: done=%b err=%b want 1 0", done, err);
    end
    @(negedge CLK_50);
    send_cmd(7'd0, 7'd0, 9'd2, 9'd5, 8'h0F);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vga_wren !== 1'b1 || vga_address !== ea[i] || vga_byteena !== eb[i]) begin
        errors++;
        $display("FAIL lane_%0d: w=%b a=%h be=%b want 1 %h %b",
                 i, vga_wren, vga_address, vga_byteena, ea[i], eb[i]);
      end
      @(negedge CLK_50); #1;
    end
    checks++;
    if (done !== 1'b1 || vga_wren !== 1'b0) begin
      errors++;
      $display("FAIL lane_done: done=%b w=%b want 1 0", done, vga_wren);
    end
    @(negedge CLK_50); #1;
  endtask

  task automatic test_reset_mid_fill;
    int writes = 0;
    send_cmd(7'd0, 7'd79, 9'd0, 9'd3, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      if (vga_wren === 1'b1) writes++;
      @(negedge CLK_50); #1;
    end
    checks++;
    if (writes !== 10 || vga_wren !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_writes: got %0d w=%b want 10 1", writes, vga_wren);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (vga_wren !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_abort: w=%b busy=%b rdy=%b want 0 0 1", vga_wren, busy, cmd_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK_50); #1;
      checks++;
      if (done !== 1'b0 || vga_wren !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done_%0d: done=%b w=%b want 0 0", i, done, vga_wren);
      end
    end
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_50); #1;
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || vga_wren !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_%0d: busy=%b rdy=%b done=%b w=%b want 0 1 0 0",
                 i, busy, cmd_ready, done, vga_wren);
      end
    end
    test_single();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill(1000, 0);
    test_fill(100, 3);
    test_illegal();
    test_boundary();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
